// File: rtl/mathip_v2_pkg.sv
// Shared types and register map for the mathip_v2_0 AXI4-Lite arithmetic engine.
package mathip_v2_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_MAC = 2'd3
  } op_e;

  localparam logic [2:0] REG_OPA     = 3'd0;
  localparam logic [2:0] REG_OPB     = 3'd1;
  localparam logic [2:0] REG_CTRL    = 3'd2;
  localparam logic [2:0] REG_STATUS  = 3'd3;
  localparam logic [2:0] REG_RES_LO  = 3'd4;
  localparam logic [2:0] REG_RES_HI  = 3'd5;
  localparam logic [2:0] REG_ACC_CLR = 3'd6;
  localparam logic [2:0] REG_ID      = 3'd7;

  localparam int CTRL_START  = 0;
  localparam int CTRL_OP_LSB = 1;
  localparam int CTRL_IE     = 3;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_ERR  = 2;

  localparam logic [31:0] DEFAULT_ID = 32'h4D41_0200;

endpackage

// File: rtl/mathip_v2_0_if.sv
// AXI4-Lite bundle between the interconnect master and the mathip_v2_0 register file.
interface mathip_v2_0_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) ();
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/mathip_v2_engine.sv
// Sequencing FSM with a 2W-bit adder and a one-bit-per-cycle shift-add multiplier.
//   state  | meaning
//   S_IDLE | waiting for start; operands latched on start
//   S_EXEC | single-cycle ADD/SUB, result valid this cycle
//   S_MULT | W shift-add steps for MUL/MAC, result valid on the last step
module mathip_v2_engine
  import mathip_v2_pkg::*;
#(
  parameter int W = 32
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_start,
  input  op_e            i_op,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  input  logic [2*W-1:0] i_acc,
  output logic           o_busy,
  output logic           o_done_pulse,
  output logic [2*W-1:0] o_result
);
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MULT} state_e;

  state_e         r_state, w_state_nxt;
  op_e            r_op;
  logic [2*W-1:0] r_mcand, r_acc, w_sum, w_addsub;
  logic [W-1:0]   r_mplier;
  logic [CW-1:0]  r_cnt;
  logic           w_last;

  assign w_last   = (r_cnt == CW'(W-1));
  assign w_sum    = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_addsub = (r_op == OP_SUB) ? (r_mcand - {{W{1'b0}}, r_mplier})
                                     : (r_mcand + {{W{1'b0}}, r_mplier});
  assign o_busy   = (r_state != S_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    o_done_pulse = 1'b0;
    o_result     = w_sum;
    case (r_state)
      S_IDLE: if (i_start) w_state_nxt = (i_op == OP_ADD || i_op == OP_SUB) ? S_EXEC : S_MULT;
      S_EXEC: begin
        o_done_pulse = 1'b1;
        o_result     = w_addsub;
        w_state_nxt  = S_IDLE;
      end
      S_MULT: if (w_last) begin
        o_done_pulse = 1'b1;
        w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Multiplicand lives in 2W bits so it can shift left without truncation.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op     <= OP_ADD;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_op     <= i_op;
          r_mcand  <= {{W{1'b0}}, i_a};
          r_mplier <= i_b;
          r_acc    <= (i_op == OP_MAC) ? i_acc : '0;
          r_cnt    <= '0;
        end
        S_MULT: begin
          r_acc    <= w_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mathip_v2_0.sv
// AXI4-Lite register file for the arithmetic engine: operands, control, status, result, ID.
module mathip_v2_0
  import mathip_v2_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 5,
  parameter logic [31:0] C_ID_VALUE         = DEFAULT_ID
) (
  input  logic          s00_axi_aclk,
  input  logic          s00_axi_aresetn,
  mathip_v2_0_if.slave  s_axi,
  output logic          irq
);
  localparam int W  = C_S_AXI_DATA_WIDTH;
  localparam int SW = W / 8;

  logic [W-1:0]   r_opa, r_opb, r_rdata, w_rd_data;
  logic [1:0]     r_op;
  logic           r_ie, r_done, r_err, r_start;
  logic [2*W-1:0] r_res, w_eng_result;
  logic           r_awready, r_bvalid, r_arready, r_rvalid;
  logic           w_wr_en, w_rd_en, w_busy, w_eng_busy, w_eng_done;
  logic           w_start_req, w_clr_req, w_w1c;
  logic [2:0]     w_wr_idx, w_rd_idx;
  logic           w_unused;

  assign w_wr_idx    = s_axi.awaddr[4:2];
  assign w_rd_idx    = s_axi.araddr[4:2];
  assign w_wr_en     = r_awready && s_axi.awvalid && s_axi.wvalid;
  assign w_rd_en     = r_arready && s_axi.arvalid;
  assign w_busy      = w_eng_busy || r_start;
  assign w_start_req = w_wr_en && (w_wr_idx == REG_CTRL) && s_axi.wstrb[0] && s_axi.wdata[CTRL_START];
  assign w_clr_req   = w_wr_en && (w_wr_idx == REG_ACC_CLR);
  assign w_w1c       = w_wr_en && (w_wr_idx == REG_STATUS) && s_axi.wstrb[0];
  assign w_unused    = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr, s_axi.araddr};

  assign s_axi.awready = r_awready;
  assign s_axi.wready  = r_awready;
  assign s_axi.bvalid  = r_bvalid;
  assign s_axi.bresp   = 2'b00;
  assign s_axi.arready = r_arready;
  assign s_axi.rvalid  = r_rvalid;
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = 2'b00;
  assign irq           = r_done && r_ie;

  mathip_v2_engine #(.W(W)) u_engine (
    .i_clk        (s00_axi_aclk),
    .i_rst_n      (s00_axi_aresetn),
    .i_start      (r_start),
    .i_op         (op_e'(r_op)),
    .i_a          (r_opa),
    .i_b          (r_opb),
    .i_acc        (r_res),
    .o_busy       (w_eng_busy),
    .o_done_pulse (w_eng_done),
    .o_result     (w_eng_result)
  );

  always_comb begin
    w_rd_data = '0;
    case (w_rd_idx)
      REG_OPA:    w_rd_data = r_opa;
      REG_OPB:    w_rd_data = r_opb;
      REG_CTRL:   w_rd_data = W'({r_ie, r_op, 1'b0});
      REG_STATUS: w_rd_data = W'({r_err, r_done, w_eng_busy});
      REG_RES_LO: w_rd_data = r_res[W-1:0];
      REG_RES_HI: w_rd_data = r_res[2*W-1:W];
      REG_ID:     w_rd_data = W'(C_ID_VALUE);
      default:    w_rd_data = '0;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_op      <= 2'b00;
      r_ie      <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_start   <= 1'b0;
      r_res     <= '0;
    end else begin
      r_awready <= !r_awready && s_axi.awvalid && s_axi.wvalid && !r_bvalid;
      if (w_wr_en)             r_bvalid <= 1'b1;
      else if (s_axi.bready)   r_bvalid <= 1'b0;

      r_arready <= !r_arready && s_axi.arvalid && !r_rvalid;
      if (w_rd_en) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
      end else if (s_axi.rready) begin
        r_rvalid <= 1'b0;
      end

      r_start <= w_start_req && !w_busy;

      for (int i = 0; i < SW; i++) begin
        if (w_wr_en && w_wr_idx == REG_OPA && s_axi.wstrb[i]) r_opa[i*8 +: 8] <= s_axi.wdata[i*8 +: 8];
        if (w_wr_en && w_wr_idx == REG_OPB && s_axi.wstrb[i]) r_opb[i*8 +: 8] <= s_axi.wdata[i*8 +: 8];
      end
      if (w_wr_en && w_wr_idx == REG_CTRL && s_axi.wstrb[0]) begin
        r_op <= s_axi.wdata[CTRL_OP_LSB +: 2];
        r_ie <= s_axi.wdata[CTRL_IE];
      end

      // Completion beats a same-cycle W1C so a finished result is never lost.
      if (w_eng_done)                         r_done <= 1'b1;
      else if (w_w1c && s_axi.wdata[ST_DONE]) r_done <= 1'b0;

      if ((w_start_req || w_clr_req) && w_busy) r_err <= 1'b1;
      else if (w_w1c && s_axi.wdata[ST_ERR])    r_err <= 1'b0;

      if (w_eng_done)                r_res <= w_eng_result;
      else if (w_clr_req && !w_busy) r_res <= '0;
    end
  end

endmodule

// File: doc/mathip_v2_0.md
# mathip_v2_0

AXI4-Lite slave arithmetic engine, successor to the 4-register mathip v1.1. Software writes two operands, selects an operation (ADD, SUB, MUL, MAC), and starts it through a control register. It then polls STATUS or takes the interrupt and reads a double-width result. The block sits behind the PS/interconnect master port, like every other register-mapped IP in the lab designs.

## Interface
- C_S_AXI_DATA_WIDTH, 32: operand/register width W; 32 or 64 only.
- C_S_AXI_ADDR_WIDTH, 5: byte address width; must be ≥ 5 (8 registers, 4-byte stride).
- C_ID_VALUE, 32'h4D41_0200: constant returned by the ID register.
- s00_axi_aclk  in  1  sole clock; all logic rising-edge.
- s00_axi_aresetn  in  1  asynchronous, active-low reset.
- s00_axi_aw{addr,prot,valid}/awready, w{data,strb,valid}/wready, b{resp,valid}/bready, ar{addr,prot,valid}/arready, r{data,resp,valid}/rready: standard AXI4-Lite, widths per parameters; prot ignored.
- irq  out  1  level interrupt = STATUS.done & CTRL.ie.

## Operation
- Register map (addr[4:2]): 0 OPA (RW), 1 OPB (RW), 2 CTRL (RW: bit0 start, self-clearing, reads 0; bits[2:1] op 00 ADD/01 SUB/10 MUL/11 MAC; bit3 ie), 3 STATUS (bit0 busy RO, bit1 done W1C, bit2 err W1C), 4 RES_LO (RO), 5 RES_HI (RO), 6 ACC_CLR (WO: any write zeroes RES_LO/RES_HI), 7 ID (RO).
- Write strobes are byte-granular on OPA, OPB, CTRL. Writes to RO/unmapped registers are ignored. Unmapped reads return 0. bresp/rresp are always OKAY.
- All arithmetic is unsigned, in 2W bits, modulo 2^(2W):
  - ADD = {0,A}+{0,B}
  - SUB = {0,A}−{0,B}, so RES_HI is all-ones when A<B
  - MUL = A·B
  - MAC = {RES_HI,RES_LO} + A·B
- Operands and op are latched at start. OPA/OPB may be rewritten while busy without affecting the running operation.
- Start while busy: ignored and sets err. ACC_CLR while busy: ignored and sets err.
- done is sticky. If a completion and a W1C of done land in the same cycle, the set wins. A new start clears nothing except busy→1.
- FSM (sub-module): IDLE → (start) → ADD/SUB: EXEC, 1 cycle → IDLE. MUL/MAC: MULT, W cycles shift-add, one multiplier bit per cycle → IDLE.
- Reset mid-operation: the FSM returns to IDLE and all registers clear. No result is written.

## Timing
- Reset values: awready, wready, bvalid, arready, rvalid, irq = 0; rdata = 0; all registers 0 except ID.
- Write channel: awready and wready pulse together for 1 cycle only when awvalid & wvalid & !bvalid. The register update happens on that edge. bvalid rises the next cycle and holds until bready. No second write is accepted while bvalid = 1.
- Read channel: arready pulses 1 cycle when arvalid & !rvalid. rdata is registered and rvalid rises the next cycle, holding until rready. A read of STATUS reflects the value after the previous edge.
- Start handshake at edge T: busy = 1 from T+1.
  - ADD/SUB: result, done = 1 and busy = 0 at T+2.
  - MUL/MAC: result, done = 1 and busy = 0 at T+1+W (W = 32 → 33 cycles after handshake).
- irq follows done/ie combinationally from registers, with no extra latency.

## Structure
- Package mathip_v2_pkg: op_e enum (OP_ADD, OP_SUB, OP_MUL, OP_MAC), register index localparams, STATUS/CTRL bit positions, default ID.
- Sub-module mathip_v2_engine: the FSM plus shift-add multiplier and adder.
  - Inputs: start, op, A, B, acc_in.
  - Outputs: busy, done_pulse, result[2W-1:0].
- The top holds the AXI-Lite interface and register file.

## Test plan
- Reset held 100 ns, then release → all AXI outputs 0; ID reads 0x4D410200; STATUS reads 0.
- OPA = 0xFFFFFFFF, OPB = 1, CTRL = start|ADD → done at T+2; RES_LO = 0, RES_HI = 1; irq stays 0 (ie = 0).
- OPA = 3, OPB = 5, CTRL = start|SUB|ie → RES_LO = 0xFFFFFFFE, RES_HI = 0xFFFFFFFF; irq = 1 until STATUS write 0x2, then 0.
- OPA = 0xFFFFFFFF, OPB = 0xFFFFFFFF, MUL → busy exactly 32 cycles; RES_HI = 0xFFFFFFFE, RES_LO = 0x00000001.
- ACC_CLR, then MAC with 7×6 twice → RES_LO = 84. A second start issued while busy sets err and does not disturb the result.
- Assert reset 10 cycles into MUL → busy = 0, results 0; a fresh ADD 2+2 afterwards gives RES_LO = 4.
- bready held low 20 cycles after a write → bvalid stays 1, awready never pulses for the queued next write, and that write completes after bready.
